// File: rtl/vip_frame_source_pkg.sv
// Shared types and constants for the synthetic VIP frame source.
// Holds the FSM states, pattern codes and the noise LFSR definition.
package vip_src_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VS     = 2'd1,
    VBP    = 2'd2,
    ACTIVE = 2'd3
  } src_state_e;

  localparam logic [1:0] PAT_RAMP  = 2'd0;
  localparam logic [1:0] PAT_CHECK = 2'd1;
  localparam logic [1:0] PAT_DOTS  = 2'd2;
  localparam logic [1:0] PAT_FLAT  = 2'd3;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/vip_frame_source_if.sv
// Pixel stream bundle between the frame source and the morphology chain.
// No backpressure: the master drives one pixel per clock.
interface vip_frame_source_if;
  logic       post_frame_vsync;
  logic       post_frame_href;
  logic [7:0] post_img_Gray;
  logic       frame_done;

  modport master (
    output post_frame_vsync,
    output post_frame_href,
    output post_img_Gray,
    output frame_done
  );

  modport slave (
    input post_frame_vsync,
    input post_frame_href,
    input post_img_Gray,
    input frame_done
  );
endinterface

// File: rtl/vip_pattern_gen.sv
// Combinational test-pattern lookup: (x, y, pattern) -> gray, with optional inversion.
// Only the coordinate bits the patterns depend on are passed in.
module vip_pattern_gen
  import vip_src_pkg::*;
(
  input  logic [7:0] i_x,
  input  logic [5:0] i_y,
  input  logic [1:0] i_pat,
  input  logic       i_noise_inv,
  output logic [7:0] o_gray
);

  logic [7:0] w_base;

  always_comb begin
    w_base = 8'h00;
    case (i_pat)
      PAT_RAMP:  w_base = i_x;
      PAT_CHECK: w_base = (i_x[5] ^ i_y[5]) ? 8'h00 : 8'hFF;
      PAT_DOTS:  w_base = (i_x[3:0] == 4'd0 && i_y[3:0] == 4'd0) ? 8'hFF : 8'h00;
      default:   w_base = 8'h80;
    endcase
  end

  assign o_gray = w_base ^ {8{i_noise_inv}};

endmodule

// File: rtl/vip_frame_source.sv
// Synthetic vsync/href/gray frame source with four built-in test patterns.
// Define VIP_SRC_NOISE_EN to add LFSR-driven salt/pepper pixel inversion.
module vip_frame_source
  import vip_src_pkg::*;
#(
  parameter logic [9:0]  IMG_HDISP = 10'd640,
  parameter logic [9:0]  IMG_VDISP = 10'd480,
  parameter logic [10:0] H_BLANK   = 11'd160,
  parameter logic [9:0]  V_SYNC    = 10'd2,
  parameter logic [9:0]  V_BP      = 10'd33
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [1:0]         pattern_sel,
  output logic               busy,
  vip_frame_source_if.master src
);

  localparam logic [10:0] LINE = {1'b0, IMG_HDISP} + H_BLANK;

  src_state_e  r_state, w_state_nxt;
  logic [10:0] r_hcnt, w_hcnt_nxt;
  logic [9:0]  r_vcnt, w_vcnt_nxt;
  logic [1:0]  r_pat, w_pat_nxt;
  logic [9:0]  w_lim;
  logic        w_line_end, w_last_line;

  logic        r_busy, r_vsync, r_href, r_frame_done;
  logic [7:0]  r_gray;
  logic        w_busy_nxt, w_vsync_nxt, w_href_nxt, w_fd_nxt;
  logic [7:0]  w_gray_nxt, w_pat_gray;
  logic        w_noise_inv;

  // State register; outputs are registered from next-state values so they align with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_hcnt       <= 11'd0;
      r_vcnt       <= 10'd0;
      r_pat        <= PAT_RAMP;
      r_busy       <= 1'b0;
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_gray       <= 8'h00;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hcnt       <= w_hcnt_nxt;
      r_vcnt       <= w_vcnt_nxt;
      r_pat        <= w_pat_nxt;
      r_busy       <= w_busy_nxt;
      r_vsync      <= w_vsync_nxt;
      r_href       <= w_href_nxt;
      r_gray       <= w_gray_nxt;
      r_frame_done <= w_fd_nxt;
    end
  end

  always_comb begin
    case (r_state)
      VS:      w_lim = V_SYNC;
      VBP:     w_lim = V_BP;
      default: w_lim = IMG_VDISP;
    endcase
  end

  assign w_line_end  = (r_hcnt == LINE - 11'd1);
  assign w_last_line = (r_vcnt == w_lim - 10'd1);

  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_vcnt_nxt  = r_vcnt;
    w_pat_nxt   = r_pat;
    if (r_state == IDLE) begin
      if (run) begin
        w_state_nxt = VS;
        w_hcnt_nxt  = 11'd0;
        w_vcnt_nxt  = 10'd0;
        w_pat_nxt   = pattern_sel;
      end
    end else begin
      w_hcnt_nxt = w_line_end ? 11'd0 : r_hcnt + 11'd1;
      if (w_line_end) begin
        w_vcnt_nxt = w_last_line ? 10'd0 : r_vcnt + 10'd1;
        if (w_last_line) begin
          case (r_state)
            VS:  w_state_nxt = (V_BP == 10'd0) ? ACTIVE : VBP;
            VBP: w_state_nxt = ACTIVE;
            default: begin
              w_state_nxt = run ? VS : IDLE;
              if (run) w_pat_nxt = pattern_sel;
            end
          endcase
        end
      end
    end
  end

  vip_pattern_gen u_pattern_gen (
    .i_x         (w_hcnt_nxt[7:0]),
    .i_y         (w_vcnt_nxt[5:0]),
    .i_pat       (w_pat_nxt),
    .i_noise_inv (w_noise_inv),
    .o_gray      (w_pat_gray)
  );

  always_comb begin
    w_busy_nxt  = (w_state_nxt != IDLE);
    w_vsync_nxt = (w_state_nxt == VS);
    w_href_nxt  = (w_state_nxt == ACTIVE) && (w_hcnt_nxt < {1'b0, IMG_HDISP});
    w_fd_nxt    = (w_state_nxt == ACTIVE) && (w_vcnt_nxt == IMG_VDISP - 10'd1) &&
                  (w_hcnt_nxt == LINE - 11'd1);
    w_gray_nxt  = w_href_nxt ? w_pat_gray : 8'h00;
  end

`ifdef VIP_SRC_NOISE_EN
  logic [15:0] r_lfsr;

  // The value before the step decides the pixel about to be emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_href_nxt) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign w_noise_inv = (r_lfsr[5:0] == 6'd0);
`else
  assign w_noise_inv = 1'b0;
`endif

  assign busy                 = r_busy;
  assign src.post_frame_vsync = r_vsync;
  assign src.post_frame_href  = r_href;
  assign src.post_img_Gray    = r_gray;
  assign src.frame_done       = r_frame_done;

endmodule

// File: doc/vip_frame_source.md
# vip_frame_source

Synthetic video stream source for the VIP pipeline. It generates frame timing and pixel data in the same href/gray streaming format that the binary erosion/dilation handler consumes: `post_frame_vsync`, `post_frame_href` and `post_img_Gray`, one pixel per `clk`, with no backpressure. It drives the morphology chain in simulation and in on-board bring-up, in place of the CMOS capture path, and selects one of four built-in test patterns.

## Interface
- `IMG_HDISP`, 10'd640, active pixels per line
- `IMG_VDISP`, 10'd480, active lines per frame
- `H_BLANK`, 11'd160, idle cycles after each active line (≥1)
- `V_SYNC`, 10'd2, lines with vsync high at frame start (≥1)
- `V_BP`, 10'd33, back-porch lines after vsync, href low (≥0)
- `clk`  in  1  pixel clock, single clock domain
- `rst`  in  1  reset, synchronous, active-high
- `run`  in  1  level; 1 = produce frames continuously, 0 = stop at the next frame boundary
- `pattern_sel`  in  2  pattern code, sampled on frame start
- `busy`  out  1  high while not IDLE
- `post_frame_vsync`  out  1  frame sync
- `post_frame_href`  out  1  pixel valid
- `post_img_Gray`  out  8  pixel value; 0 whenever href=0
- `frame_done`  out  1  one-cycle pulse on the last cycle of the last active line

## Operation
- Line length LINE = IMG_HDISP + H_BLANK. `hcnt` (11b) counts 0..LINE-1 and wraps. `vcnt` (10b) counts lines within the current state.
- FSM states: IDLE, VS, VBP, ACTIVE.
  - IDLE→VS when `run`=1. `pattern_sel` is latched into `pat_q` on this transition.
  - VS lasts V_SYNC lines with vsync=1, then goes to VBP. If V_BP=0 it goes straight to ACTIVE.
  - VBP lasts V_BP lines with all outputs 0, then goes to ACTIVE.
  - ACTIVE lasts IMG_VDISP lines. href=1 for `hcnt` < IMG_HDISP, then H_BLANK cycles of href=0 with gray=0.
  - After the last ACTIVE cycle: go to VS if `run`=1, relatching `pattern_sel`; otherwise go to IDLE.
- Pixel coordinates are x=`hcnt`, y=`vcnt` (ACTIVE only). Patterns by `pat_q`:
  - 0: ramp, gray = x[7:0]
  - 1: checker, gray = (x[5]^y[5]) ? 0 : 255
  - 2: dots, gray = 255 if x[3:0]==0 && y[3:0]==0, else 0 (isolated pixels; an opening must remove them)
  - 3: flat, gray = 8'h80
- `run` falling mid-frame never truncates the frame. The frame completes, then the FSM enters IDLE.
- `rst` at any cycle: on the next edge the FSM is in IDLE, counters are 0, and all outputs are 0.

## Timing
- All outputs are registered. Reset values: `busy`, `post_frame_vsync`, `post_frame_href`, `post_img_Gray` and `frame_done` are all 0.
- `run` sampled 1 in IDLE at edge t: vsync and busy are high from cycle t+1.
- The first href cycle is t+1+(V_SYNC+V_BP)·LINE.
- Frame period = (V_SYNC+V_BP+IMG_VDISP)·LINE cycles. Consecutive frames are back-to-back, with no IDLE cycle between them.
- `frame_done` and the FSM leaving ACTIVE occur on the same cycle. `busy` falls the cycle after `frame_done` when `run`=0.
- `pattern_sel` changes mid-frame have no effect until the next VS entry.

## Configuration
- `VIP_SRC_NOISE_EN` defined:
  - adds a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on `rst`), advancing on every href=1 cycle;
  - when LFSR[5:0]==0 the pattern value is inverted (gray ^ 8'hFF), giving salt/pepper noise;
  - this applies to all patterns.
- Not defined: no LFSR logic, and patterns are exactly as listed above.

## Structure
- Package `vip_src_pkg` holds:
  - the FSM state enum (IDLE, VS, VBP, ACTIVE);
  - pattern code constants PAT_RAMP=0, PAT_CHECK=1, PAT_DOTS=2, PAT_FLAT=3;
  - LFSR seed and tap constants.
- Sub-module `vip_pattern_gen` is combinational. It maps (x, y, pat_q) to gray, plus the optional noise-invert input. The top module registers its output.

## Test plan
The first two scenarios use small parameters: IMG_HDISP=8, IMG_VDISP=4, H_BLANK=4, V_SYNC=1, V_BP=2, giving LINE=12 and a frame of 84 cycles.
- Release `rst`, then `run`=1 sampled at cycle 0 → vsync=1 on cycles 1–12, href=1 on cycles 37–44, `frame_done` on cycle 84, vsync high again on cycle 85.
- pattern 0 → each active line carries gray 0,1,…,7 followed by 4 zero cycles. 32 href cycles per frame.
- Default parameters, pattern 1 → pixel (0,0)=255, (32,0)=0, (32,32)=255, (639,479)=0.
- Pattern 2 → exactly 40×30=1200 pixels of value 255 per frame, at (0,0), (16,0), …, (624,464).
- `run` dropped on line 2 of ACTIVE → the frame completes with `frame_done`, `busy`=0 on the next cycle, and no further vsync.
- `rst` pulsed mid active line → the next cycle has href=0, gray=0, vsync=0, busy=0. With `run`=1 held, vsync restarts one cycle after `rst` falls. With `VIP_SRC_NOISE_EN`, the inverted-pixel count per frame matches the LFSR reference model seeded with 16'hACE1.
